// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   DM_ADDR_W / DM_DATA_W : default request address and data widths
//   DM_RD_LAT_MAX         : largest supported read latency
//   DM_CNT_W              : width of the read-latency down-counter
//   dm_state_e            : responder FSM states
package dm_pkg;

  localparam int DM_ADDR_W     = 16;
  localparam int DM_DATA_W     = 8;
  localparam int DM_RD_LAT_MAX = 15;
  localparam int DM_CNT_W      = $clog2(DM_RD_LAT_MAX + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_array.sv
// Word storage behind the data-memory responder.
// Synchronous write, combinational read, no reset (contents survive reset).
// Ports:
//   clock  : system clock
//   we     : write enable, commits wdata at waddr on the rising edge
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data, combinational from raddr
module dm_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the processor data port. Accepts one request at a
// time, completes writes after one cycle and reads after RD_LAT cycles, with a
// one-cycle dm_valid pulse on completion. Out-of-range requests complete with
// the same timing and raise addr_err alongside dm_valid.
// Ports:
//   clock    : system clock
//   rst      : synchronous active-high reset
//   dm_en    : request strobe (ignored while dm_busy)
//   dm_we    : 1 = write, 0 = read
//   ar_in    : request address
//   wdata    : write data
//   dm_out   : registered read data, holds until the next read completes
//   dm_valid : one-cycle completion pulse
//   dm_busy  : multi-cycle read in flight
//   addr_err : completed request was out of range (qualified by dm_valid)
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              dm_en,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] dm_out,
  output logic              dm_valid,
  output logic              dm_busy,
  output logic              addr_err
);

  localparam int                 IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [DM_CNT_W-1:0] LAT_LOAD = DM_CNT_W'(RD_LAT - 1);

  dm_state_e           state_q;
  logic [DM_CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                err_q;
  logic [DATA_W-1:0]   dm_out_q;
  logic                dm_valid_q;
  logic                dm_busy_q;
  logic                addr_err_q;

  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_data;

  assign accept   = dm_en && (state_q == IDLE);
  // Range check on the full address before truncating to the word index.
  assign in_range = ({1'b0, ar_in} < DEPTH_EXT);
  assign req_idx  = ar_in[IDX_W-1:0];
  // Reset wins over a simultaneous request, so the write is gated too.
  assign wr_en    = accept && dm_we && in_range && !rst;
  // While waiting, read from the captured index; no write can land meanwhile
  // because requests are ignored when busy.
  assign rd_idx   = (state_q == IDLE) ? req_idx : idx_q;

  dm_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (wr_en),
    .waddr (req_idx),
    .wdata (wdata),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      dm_out_q   <= '0;
      dm_valid_q <= 1'b0;
      dm_busy_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      dm_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_en) begin
            if (dm_we) begin
              dm_valid_q <= 1'b1;
              addr_err_q <= !in_range;
            end else if (RD_LAT <= 1) begin
              dm_out_q   <= in_range ? rd_data : '0;
              dm_valid_q <= 1'b1;
              addr_err_q <= !in_range;
            end else begin
              state_q   <= RD_WAIT;
              dm_busy_q <= 1'b1;
              cnt_q     <= LAT_LOAD;
              idx_q     <= req_idx;
              err_q     <= !in_range;
            end
          end
        end
        RD_WAIT: begin
          // Counter value 1 marks the last waiting cycle: load data now so it
          // appears with dm_valid in the following cycle.
          if (cnt_q == DM_CNT_W'(1)) begin
            dm_out_q   <= err_q ? '0 : rd_data;
            dm_valid_q <= 1'b1;
            addr_err_q <= err_q;
            dm_busy_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - DM_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dm_out   = dm_out_q;
  assign dm_valid = dm_valid_q;
  assign dm_busy  = dm_busy_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_en = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] ar_in = '0;
  logic [7:0]  wdata = '0;

  logic [7:0]  out_w   [NI];
  logic        valid_w [NI];
  logic        busy_w  [NI];
  logic        err_w   [NI];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dm_responder #(
      .ADDR_W (16),
      .DATA_W (8),
      .DEPTH  (256),
      .RD_LAT (gi == 0 ? 1 : (gi == 1 ? 2 : 4))
    ) u_dut (
      .clock    (clk),
      .rst      (rst),
      .dm_en    (dm_en),
      .dm_we    (dm_we),
      .ar_in    (ar_in),
      .wdata    (wdata),
      .dm_out   (out_w[gi]),
      .dm_valid (valid_w[gi]),
      .dm_busy  (busy_w[gi]),
      .addr_err (err_w[gi])
    );
  end

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d (RD_LAT=%0d) cyc=%0d: got %h expected %h",
               name, k, lat_of(k), cyc, act, exp);
    end
  endtask

  // Behavioural reference: each instance tracks a word array, the cycle in
  // which its single outstanding request completes, and the last cycle it is
  // busy. Outputs are predicted from those timestamps.
  logic [7:0] mem_m    [NI][256];
  logic [7:0] held     [NI] = '{8'h00, 8'h00, 8'h00};
  int         pend_cyc [NI] = '{-1, -1, -1};
  logic [7:0] pend_dat [NI];
  bit         pend_err [NI];
  bit         pend_rd  [NI];
  int         busy_end [NI] = '{-1, -1, -1};
  bit         armed = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit ev;
      bit inr;
      ev = armed && (pend_cyc[k] == cyc);
      if (ev && pend_rd[k]) held[k] = pend_dat[k];
      if (armed) begin
        chk("valid",  k, {7'b0, valid_w[k]}, {7'b0, ev});
        chk("err",    k, {7'b0, err_w[k]},   {7'b0, ev && pend_err[k]});
        chk("busy",   k, {7'b0, busy_w[k]},  {7'b0, cyc <= busy_end[k]});
        chk("dm_out", k, out_w[k], held[k]);
      end
      inr = (ar_in < 16'd256);
      if (rst) begin
        pend_cyc[k] = -1;
        held[k]     = 8'h00;
        busy_end[k] = -1;
      end else if (armed && dm_en && (cyc > busy_end[k])) begin
        pend_err[k] = !inr;
        if (dm_we) begin
          if (inr) mem_m[k][ar_in[7:0]] = wdata;
          pend_rd[k]  = 1'b0;
          pend_cyc[k] = cyc + 1;
        end else begin
          pend_rd[k]  = 1'b1;
          pend_dat[k] = inr ? mem_m[k][ar_in[7:0]] : 8'h00;
          pend_cyc[k] = cyc + lat_of(k);
          if (lat_of(k) > 1) busy_end[k] = cyc + lat_of(k) - 1;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit we, input logic [15:0] a, input logic [7:0] d);
    dm_en = en;
    dm_we = we;
    ar_in = a;
    wdata = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] pv;

    // Reset for two cycles, then idle.
    step();
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("rst_out",   k, out_w[k], 8'h00);
      chk("rst_valid", k, {7'b0, valid_w[k]}, 8'h00);
      chk("rst_busy",  k, {7'b0, busy_w[k]}, 8'h00);
      chk("rst_err",   k, {7'b0, err_w[k]}, 8'h00);
    end
    idle(3);
    chk("idle_valid", 2, {7'b0, valid_w[2]}, 8'h00);

    // Preload every word so later reads are fully defined.
    for (int a = 0; a < 256; a++) begin
      case (a)
        0:       pv = 8'h3C;
        1:       pv = 8'h11;
        2:       pv = 8'h22;
        3:       pv = 8'h33;
        default: pv = 8'($urandom);
      endcase
      drive(1'b1, 1'b1, 16'(a), pv);
      step();
    end
    idle(2);

    // Write then read, RD_LAT=2 instance.
    drive(1'b1, 1'b1, 16'h0010, 8'hA5);
    step();
    chk("wr_valid", 1, {7'b0, valid_w[1]}, 8'h01);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    step();
    chk("rd_busy", 1, {7'b0, busy_w[1]}, 8'h01);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    chk("rd_data",  1, out_w[1], 8'hA5);
    chk("rd_valid", 1, {7'b0, valid_w[1]}, 8'h01);
    chk("rd_busy0", 1, {7'b0, busy_w[1]}, 8'h00);
    idle(6);

    // Write while busy is dropped on multi-cycle instances.
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    step();
    drive(1'b1, 1'b1, 16'h0010, 8'hFF);
    step();
    idle(6);
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    step();
    chk("bi_lat1", 0, out_w[0], 8'hFF);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    chk("bi_lat2", 1, out_w[1], 8'hA5);
    step();
    step();
    chk("bi_lat4", 2, out_w[2], 8'hA5);
    idle(4);

    // Out of range write and read.
    drive(1'b1, 1'b1, 16'h0100, 8'h77);
    step();
    for (int k = 0; k < NI; k++) chk("oor_wr_err", k, {7'b0, err_w[k] & valid_w[k]}, 8'h01);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    drive(1'b1, 1'b0, 16'h0100, 8'h00);
    step();
    chk("oor_rd0", 0, {out_w[0][6:0], err_w[0]}, 8'h01);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    chk("oor_rd1", 1, {out_w[1][6:0], err_w[1]}, 8'h01);
    step();
    step();
    chk("oor_rd2", 2, {out_w[2][6:0], err_w[2]}, 8'h01);
    idle(2);
    drive(1'b1, 1'b0, 16'h0000, 8'h00);
    step();
    chk("addr0_keep", 0, out_w[0], 8'h3C);
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    step();
    step();
    chk("addr0_keep", 2, out_w[2], 8'h3C);
    idle(2);

    // Reset in the middle of a RD_LAT=4 read.
    drive(1'b1, 1'b0, 16'h0002, 8'h00);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out",  2, out_w[2], 8'h00);
    chk("mid_rst_busy", 2, {7'b0, busy_w[2]}, 8'h00);
    step();
    chk("mid_rst_novalid", 2, {7'b0, valid_w[2]}, 8'h00);
    step();
    drive(1'b1, 1'b0, 16'h0001, 8'h00);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    step();
    step();
    chk("post_rst_rd", 2, out_w[2], 8'h11);
    chk("post_rst_valid", 2, {7'b0, valid_w[2]}, 8'h01);
    idle(2);

    // Back-to-back reads on the RD_LAT=1 instance.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 16'(i), 8'h00);
      step();
      chk("b2b_data",  0, out_w[0], 8'(i * 8'h11));
      chk("b2b_valid", 0, {7'b0, valid_w[0]}, 8'h01);
    end
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    chk("b2b_end", 0, {7'b0, valid_w[0]}, 8'h00);
    idle(6);

    // Randomised traffic, checked cycle by cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 299));
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom), 1'($urandom), a, 8'($urandom));
      step();
    end
    rst = 1'b0;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder serving the processor's data-memory port.
- Accepts read/write requests driven by the processor's AR (address), bus low byte (write data) and `dm_en`.
- Returns read data on `dm_out` after a parameterised latency, with a one-cycle completion pulse.
- Sits between the processor top and the matrix storage; models real SRAM wait states so the control unit can be exercised against multi-cycle memory.

Parameters:
- ADDR_W, 16, width of request address (matches AR width)
- DATA_W, 8, data word width (matches `dm_out` width)
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range
- RD_LAT, 2, read latency in cycles from accept to data valid; legal range 1..15

Ports:
- clock  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- dm_en  in  1  request strobe from processor
- dm_we  in  1  1 = write, 0 = read; sampled with `dm_en`
- ar_in  in  ADDR_W  request address
- wdata  in  DATA_W  write data (bus_out[7:0])
- dm_out  out  DATA_W  registered read data
- dm_valid  out  1  one-cycle completion pulse (read data valid / write ack)
- dm_busy  out  1  request in flight; new `dm_en` ignored while high
- addr_err  out  1  pulses with `dm_valid` when the completed request was out of range

Behaviour:
- One clock domain: `clock`. `rst` is synchronous and active-high.
- Reset values: `dm_out`=0, `dm_valid`=0, `dm_busy`=0, `addr_err`=0, FSM=IDLE, latency counter=0. Storage array is not cleared by reset.
- FSM states: IDLE, RD_WAIT.
- Accept: request accepted in cycle T when `dm_en`=1 and the FSM is in IDLE. `ar_in`, `dm_we` and `wdata` are captured at the end of T.
- Write:
  - Array updated at the end of cycle T.
  - `dm_valid`=1 in cycle T+1.
  - `dm_busy` stays 0; FSM remains in IDLE.
- Read with RD_LAT=1: `dm_out` loaded at the end of T; `dm_valid`=1 in T+1; `dm_busy` stays 0.
- Read with RD_LAT>1:
  - FSM moves to RD_WAIT; `dm_busy`=1 in cycles T+1 .. T+RD_LAT-1.
  - Counter loads RD_LAT-1 and decrements each cycle; width is clog2(16).
  - When the counter reaches 1, `dm_out` is loaded and the FSM returns to IDLE.
  - `dm_valid`=1 and `dm_busy`=0 in cycle T+RD_LAT.
- Back-to-back: a new request may be accepted in the same cycle that `dm_valid` is high.
- `dm_en` while `dm_busy`=1: ignored, no queueing; the processor must re-assert after completion.
- `dm_out` holds the last read value until the next read completes; writes do not change it.
- Out of range (`ar_in` >= DEPTH):
  - Write: discarded, array unchanged.
  - Read: `dm_out` loaded with 0.
  - In both cases `addr_err`=1 together with `dm_valid`, with the same latency as an in-range access.
- Address decode uses only the low clog2(DEPTH) bits, after the range check on the full ADDR_W.
- Read-after-write to the same address: the write is committed before any later accept, so the read returns the new data.
- Reset mid-read: FSM returns to IDLE, no `dm_valid` is produced, and `dm_out` is forced to 0.
- Reset together with `dm_en`: reset wins and the request is dropped.
- `dm_we` and `wdata` are ignored when `dm_en`=0.

Decomposition:
- Package `dm_pkg` contains:
  - FSM state enum (IDLE, RD_WAIT)
  - default widths ADDR_W=16, DATA_W=8
  - RD_LAT maximum constant 15
- Sub-module `dm_array`:
  - DEPTH x DATA_W storage, synchronous write, combinational read
  - no reset
  - instantiated once by `dm_responder`, which owns the FSM, counter, range check and output registers.

Test Plan:
- Reset then idle: after `rst` high for 2 cycles → `dm_out`=0x00, `dm_valid`=0, `dm_busy`=0, `addr_err`=0; stays so with `dm_en`=0.
- Write then read, RD_LAT=2: write 0xA5 to addr 0x0010 at T → `dm_valid` at T+1. Read 0x0010 at T+2 → `dm_busy`=1 at T+3; `dm_out`=0xA5 with `dm_valid`=1, `dm_busy`=0 at T+4.
- Busy ignore: read 0x0010 accepted at T; `dm_en`=1 with write 0xFF to 0x0010 at T+1 (busy) → write dropped; a later read of 0x0010 returns 0xA5.
- Out of range, DEPTH=256: write 0x77 to 0x0100, then read 0x0100 → each completion has `addr_err`=1; read `dm_out`=0x00; addr 0x0000 is unchanged.
- Reset mid-read, RD_LAT=4: read accepted at T; `rst`=1 at T+2 → no `dm_valid` at T+4; `dm_out`=0; next request is accepted normally.
- Back-to-back, RD_LAT=1: reads of 0x01, 0x02, 0x03 on consecutive cycles, preloaded with 0x11, 0x22, 0x33 → `dm_valid` high 3 consecutive cycles, data 0x11, 0x22, 0x33.
